branch_seq: RTL and testbench

Multi-cycle branch sequencer for the Mini SRC datapath and the initiator for the condition flip-flop (CON FF). On a start pulse it latches the branch instruction, drives register Ra onto the bus with CONin asserted and the C2 condition field selected, and samples the CON FF result one cycle later. It then commits the branch target `PC + sext(C)` into the PC. It sits between the control unit's T-step sequencer and the PC register, and keeps saturating statistics counters.

---
 rtl/minisrc_pkg.sv | 35 +++
 rtl/sat_counter.sv | 20 ++
 rtl/branch_seq.sv | 125 ++++++++++++
 tb/tb_branch_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: branch sequencer states, CON FF
// condition encodings, IR field bounds and opcode values.
package minisrc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EVAL    = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_COMMIT  = 2'd3
  } br_state_t;

  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int C2_MSB = 20;
  localparam int C2_LSB = 19;
  localparam int C_MSB  = 18;
  localparam int C_LSB  = 0;

  localparam logic [4:0] OP_LD     = 5'b00000;
  localparam logic [4:0] OP_ST     = 5'b00010;
  localparam logic [4:0] BR_OPCODE = 5'b10010;

  // Sign-extends the 19-bit C field to a full 32-bit offset.
  function automatic logic [31:0] sextC(input logic [18:0] c);
    return {{13{c[18]}}, c};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc unless already at the all-ones ceiling.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_seq.sv
// Multi-cycle conditional branch sequencer for the Mini SRC datapath.
// Drives Ra into the CON FF for one cycle, samples the result, then
// commits PC + sext(C) and keeps saturating branch statistics.
module branch_seq #(
  parameter logic [4:0] BR_OPCODE = minisrc_pkg::BR_OPCODE,
  parameter int         CNT_W     = 16
) (
  input  logic             Clock,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [31:0]      IR,
  input  logic [31:0]      RaData,
  input  logic [31:0]      PC,
  input  logic             BranchOut,
  output logic             CONin,
  output logic [1:0]       CondSel,
  output logic [31:0]      BusOut,
  output logic             Busy,
  output logic             Done,
  output logic             Taken,
  output logic             PCload,
  output logic [31:0]      PCnext,
  output logic             BadOp,
  output logic [CNT_W-1:0] BrCount,
  output logic [CNT_W-1:0] TakenCount
);

  import minisrc_pkg::*;

  br_state_t   r_state;
  br_state_t   w_next;
  logic [1:0]  r_cond;
  logic [18:0] r_off;
  logic [31:0] r_pc;
  logic        r_bad;
  logic        r_taken;
  logic        w_isBranch;
  logic        w_incBr;
  logic        w_incTaken;
  logic        w_unusedIr;

  assign w_isBranch = (IR[OP_MSB:OP_LSB] == BR_OPCODE);
  assign w_unusedIr = ^IR[RA_MSB:C2_MSB+1];

  // State register plus the instruction fields and branch outcome latches.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_cond  <= 2'b00;
      r_off   <= '0;
      r_pc    <= '0;
      r_bad   <= 1'b0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && Start) begin
        r_cond  <= IR[C2_MSB:C2_LSB];
        r_off   <= IR[C_MSB:C_LSB];
        r_pc    <= PC;
        r_bad   <= !w_isBranch;
        r_taken <= 1'b0;
      end
      if (r_state == ST_RESOLVE) begin
        r_taken <= BranchOut;
      end
    end
  end

  // Next-state decode and per-state datapath outputs.
  always_comb begin
    w_next = r_state;
    CONin  = 1'b0;
    BusOut = '0;
    Done   = 1'b0;
    PCload = 1'b0;
    PCnext = '0;
    BadOp  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (Start) begin
          w_next = w_isBranch ? ST_EVAL : ST_COMMIT;
        end
      end
      ST_EVAL: begin
        CONin  = 1'b1;
        BusOut = RaData;
        w_next = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        w_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        Done   = 1'b1;
        PCload = r_taken && !r_bad;
        PCnext = r_pc + sextC(r_off);
        BadOp  = r_bad;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign CondSel    = r_cond;
  assign Busy       = (r_state != ST_IDLE);
  assign Taken      = r_taken;
  assign w_incBr    = (r_state == ST_COMMIT) && !r_bad;
  assign w_incTaken = (r_state == ST_COMMIT) && !r_bad && r_taken;

  sat_counter #(.W(CNT_W)) u_brCount (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .inc     (w_incBr),
    .count   (BrCount)
  );

  sat_counter #(.W(CNT_W)) u_takenCount (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .inc     (w_incTaken),
    .count   (TakenCount)
  );

endmodule

// File: tb/tb_branch_seq.sv
// Self-checking bench for branch_seq with a behavioural CON FF and a
// scoreboard of expected commit results.
module tb_branch_seq;
  import minisrc_pkg::*;

  localparam int CW = 2;

  logic          Clock;
  logic          Reset_n;
  logic          Start;
  logic [31:0]   IR;
  logic [31:0]   RaData;
  logic [31:0]   PC;
  logic          BranchOut;
  logic          CONin;
  logic [1:0]    CondSel;
  logic [31:0]   BusOut;
  logic          Busy;
  logic          Done;
  logic          Taken;
  logic          PCload;
  logic [31:0]   PCnext;
  logic          BadOp;
  logic [CW-1:0] BrCount;
  logic [CW-1:0] TakenCount;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] ra;
    logic        expTaken;
    logic [31:0] expPcNext;
    logic        expBad;
  } vec_t;

  typedef struct {
    logic        expTaken;
    logic [31:0] expPcNext;
    logic        expBad;
    int          expLat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   errors = 0;
  int   checks = 0;
  int   modelBr = 0;
  int   modelTk = 0;
  logic conFf = 1'b0;

  branch_seq #(.BR_OPCODE(5'b10010), .CNT_W(CW)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .IR         (IR),
    .RaData     (RaData),
    .PC         (PC),
    .BranchOut  (BranchOut),
    .CONin      (CONin),
    .CondSel    (CondSel),
    .BusOut     (BusOut),
    .Busy       (Busy),
    .Done       (Done),
    .Taken      (Taken),
    .PCload     (PCload),
    .PCnext     (PCnext),
    .BadOp      (BadOp),
    .BrCount    (BrCount),
    .TakenCount (TakenCount)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic condTrue(input logic [31:0] v, input logic [1:0] c);
    case (c)
      COND_ZR: return (v == 32'd0);
      COND_NZ: return (v != 32'd0);
      COND_PL: return !v[31];
      default: return v[31];
    endcase
  endfunction

  // CON FF: loads the condition result when CONin is high, clears otherwise.
  always @(posedge Clock) begin
    if (!CONin) conFf <= 1'b0;
    else        conFf <= condTrue(BusOut, CondSel);
  end
  assign BranchOut = conFf;

  function automatic logic [31:0] mkIr(input logic [4:0] op, input logic [1:0] c2,
                                       input logic [18:0] c);
    return {op, 4'd3, 2'b00, c2, c};
  endfunction

  function automatic logic [31:0] satv(input int n);
    int top;
    top = (1 << CW) - 1;
    return (n > top) ? top : n;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_conin"}, CONin, 0);
    checkOutput({tag, "_condsel"}, CondSel, 0);
    checkOutput({tag, "_bus"}, BusOut, 0);
    checkOutput({tag, "_busy"}, Busy, 0);
    checkOutput({tag, "_done"}, Done, 0);
    checkOutput({tag, "_taken"}, Taken, 0);
    checkOutput({tag, "_pcload"}, PCload, 0);
    checkOutput({tag, "_pcnext"}, PCnext, 0);
    checkOutput({tag, "_badop"}, BadOp, 0);
    checkOutput({tag, "_brcount"}, BrCount, 0);
    checkOutput({tag, "_tkcount"}, TakenCount, 0);
  endtask

  task automatic applyReset();
    @(negedge Clock);
    Reset_n = 1'b0;
    Start   = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    modelBr = 0;
    modelTk = 0;
    checkAllZero("reset");
    @(negedge Clock);
    Reset_n = 1'b1;
  endtask

  // Issues one instruction and follows it cycle by cycle to its commit.
  task automatic applyStimulus(input vec_t v, input bit poke);
    exp_t e;
    exp_t got;
    int   cyc;
    int   conCnt;
    int   extraDone;
    bit   seen;
    @(negedge Clock);
    Start  = 1'b1;
    IR     = v.ir;
    PC     = v.pc;
    RaData = v.ra;
    e.expTaken  = v.expTaken;
    e.expPcNext = v.expPcNext;
    e.expBad    = v.expBad;
    e.expLat    = v.expBad ? 1 : 3;
    sb.push_back(e);
    @(posedge Clock);
    #1;
    Start = 1'b0;
    IR    = 32'hFFFF_FFFF;
    PC    = 32'hDEAD_BEEF;
    cyc    = 1;
    conCnt = 0;
    seen   = 1'b0;
    checkOutput("busy_c1", Busy, 1);
    checkOutput("taken_cleared", Taken, 0);
    while (!seen && cyc <= 8) begin
      if (CONin) begin
        conCnt++;
        checkOutput("bus_eval", BusOut, v.ra);
        checkOutput("condsel_eval", CondSel, v.ir[20:19]);
      end else begin
        checkOutput("bus_idle", BusOut, 0);
      end
      if (poke && cyc == 1) begin
        Start = 1'b1;
        IR    = mkIr(5'b00000, 2'b00, 19'h1);
      end
      if (Done) begin
        seen = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_empty: got Done expected no Done");
        end else begin
          got = sb.pop_front();
          checkOutput("done_latency", cyc, got.expLat);
          checkOutput("pcload", PCload, got.expTaken);
          checkOutput("pcnext", PCnext, got.expPcNext);
          checkOutput("badop", BadOp, got.expBad);
          checkOutput("taken", Taken, got.expTaken);
          if (!got.expBad) modelBr++;
          if (!got.expBad && got.expTaken) modelTk++;
        end
        if (poke) begin
          Start = 1'b1;
          IR    = mkIr(5'b00000, 2'b00, 19'h1);
        end
      end else begin
        checkOutput("pcload_idle", PCload, 0);
        checkOutput("pcnext_idle", PCnext, 0);
      end
      @(posedge Clock);
      #1;
      if (poke) Start = 1'b0;
      cyc++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no Done expected Done within 8 cycles");
    end
    checkOutput("conin_pulses", conCnt, v.expBad ? 0 : 1);
    checkOutput("done_width", Done, 0);
    checkOutput("pcload_width", PCload, 0);
    checkOutput("busy_after", Busy, 0);
    checkOutput("taken_hold", Taken, v.expTaken);
    checkOutput("brcount", BrCount, satv(modelBr));
    checkOutput("tkcount", TakenCount, satv(modelTk));
    if (poke) begin
      extraDone = 0;
      repeat (5) begin
        if (Done) extraDone++;
        @(posedge Clock);
        #1;
      end
      checkOutput("poke_extra_done", extraDone, 0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got hang expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pcloads;
    Reset_n = 1'b0;
    Start   = 1'b0;
    IR      = '0;
    PC      = '0;
    RaData  = '0;

    vecs[0] = '{mkIr(5'b10010, COND_ZR, 19'h00010), 32'h100, 32'h0, 1'b1, 32'h110, 1'b0};
    vecs[1] = '{mkIr(5'b10010, COND_MI, 19'h00020), 32'h200, 32'h5, 1'b0, 32'h220, 1'b0};
    vecs[2] = '{mkIr(5'b10010, COND_PL, 19'h7FFFC), 32'h2, 32'h1, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{mkIr(5'b00000, COND_ZR, 19'h00005), 32'h40, 32'h0, 1'b0, 32'h45, 1'b1};
    vecs[4] = '{mkIr(5'b10010, COND_NZ, 19'h3FFFF), 32'h1000, 32'h8000_0000, 1'b1, 32'h0004_0FFF, 1'b0};
    vecs[5] = '{mkIr(5'b10010, COND_PL, 19'h00000), 32'h10, 32'h8000_0000, 1'b0, 32'h10, 1'b0};
    vecs[6] = '{mkIr(5'b10010, COND_ZR, 19'h40000), 32'h0004_0000, 32'h7, 1'b0, 32'h0, 1'b0};
    vecs[7] = '{mkIr(5'b10010, COND_MI, 19'h00001), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0};

    applyReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], 1'b0);
    end

    applyReset();
    applyStimulus(vecs[0], 1'b1);

    // Reset while in EVAL: everything clears, no commit follows.
    @(negedge Clock);
    Start  = 1'b1;
    IR     = vecs[0].ir;
    PC     = vecs[0].pc;
    RaData = vecs[0].ra;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    checkOutput("midrst_conin_eval", CONin, 1);
    @(negedge Clock);
    Reset_n = 1'b0;
    @(posedge Clock);
    #1;
    modelBr = 0;
    modelTk = 0;
    checkAllZero("midrst");
    @(negedge Clock);
    Reset_n = 1'b1;
    pcloads = 0;
    repeat (5) begin
      @(posedge Clock);
      #1;
      if (PCload || Done) pcloads++;
    end
    checkOutput("midrst_no_commit", pcloads, 0);

    applyReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[0], 1'b0);
    end
    checkOutput("sat_brcount", BrCount, 2'b11);
    checkOutput("sat_tkcount", TakenCount, 2'b11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
